// File: rtl/dcache_nway_if.sv
// Datapath-side and memory-side bus of the N-way data cache.
// master: the environment (datapath requester plus memory controller).
// slave:  the cache itself.
interface dcache_nway_if;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport master (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport slave (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_nway.sv
// Write-back, write-allocate N-way set-associative data cache with true LRU
// replacement and a halt-time flush that ends by storing hits - misses.
module dcache_nway #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned WORDS       = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
  input logic          CLK,
  input logic          nRST,
  dcache_nway_if.slave bus
);
  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned BLKW = $clog2(WORDS);
  localparam int unsigned WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAGW = 32 - 2 - BLKW - IDXW;

  typedef enum logic [2:0] {
    IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB, STAT, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BLKW-1:0]   cnt_q, cnt_d;
  logic [WAYW-1:0]   victim_q, victim_d;
  logic [IDXW-1:0]   scan_set_q, scan_set_d;
  logic [WAYW-1:0]   scan_way_q, scan_way_d;
  logic [31:0]       hits_q, hits_d;
  logic [31:0]       misses_q, misses_d;

  logic              valid_q [SETS][WAYS];
  logic              valid_d [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic              dirty_d [SETS][WAYS];
  logic [TAGW-1:0]   tag_q   [SETS][WAYS];
  logic [TAGW-1:0]   tag_d   [SETS][WAYS];
  logic [WAYW-1:0]   age_q   [SETS][WAYS];
  logic [WAYW-1:0]   age_d   [SETS][WAYS];
  logic [31:0]       data_q  [SETS][WAYS][WORDS];
  logic [31:0]       data_d  [SETS][WAYS][WORDS];

  logic [TAGW-1:0]   req_tag;
  logic [IDXW-1:0]   req_idx;
  logic [BLKW-1:0]   req_blk;
  logic              req;
  logic              hit;
  logic [WAYW-1:0]   hit_way;
  logic              inv_found;
  logic [WAYW-1:0]   inv_way;
  logic [WAYW-1:0]   lru_way;
  logic [WAYW-1:0]   victim_way;
  logic              cnt_last;
  logic              scan_last;
  logic              unused_bytoff;

  assign req_tag       = bus.dmemaddr[31 -: TAGW];
  assign req_idx       = bus.dmemaddr[2 + BLKW +: IDXW];
  assign req_blk       = bus.dmemaddr[2 +: BLKW];
  assign req           = bus.dmemREN | bus.dmemWEN;
  assign unused_bytoff = ^bus.dmemaddr[1:0];
  assign cnt_last      = (cnt_q == BLKW'(WORDS - 1));
  assign scan_last     = (scan_set_q == IDXW'(SETS - 1)) && (scan_way_q == WAYW'(WAYS - 1));

  // Tag compare and victim choice (lowest invalid way, else the LRU way).
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!valid_q[req_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAYW'(w);
      end
      if (age_q[req_idx][w] == WAYW'(WAYS - 1)) lru_way = WAYW'(w);
    end
    victim_way = inv_found ? inv_way : lru_way;
  end

  // Next-state, array updates and bus outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    victim_d     = victim_q;
    scan_set_d   = scan_set_q;
    scan_way_d   = scan_way_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    age_d        = age_q;
    data_d       = data_q;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.flushed  = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (bus.halt) begin
          state_d    = FLUSH_SCAN;
          scan_set_d = '0;
          scan_way_d = '0;
        end else if (req) begin
          if (hit) begin
            bus.dhit = 1'b1;
            hits_d   = hits_q + 32'd1;
            if (bus.dmemREN) bus.dmemload = data_q[req_idx][hit_way][req_blk];
            if (bus.dmemWEN) begin
              data_d[req_idx][hit_way][req_blk] = bus.dmemstore;
              dirty_d[req_idx][hit_way]         = 1'b1;
            end
            for (int unsigned w = 0; w < WAYS; w++) begin
              if (WAYW'(w) == hit_way)
                age_d[req_idx][w] = '0;
              else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                age_d[req_idx][w] = age_q[req_idx][w] + WAYW'(1);
            end
          end else begin
            misses_d = misses_q + 32'd1;
            victim_d = victim_way;
            cnt_d    = '0;
            state_d  = (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) ? WB : FILL;
          end
        end
      end

      WB: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tag_q[req_idx][victim_q], req_idx, cnt_q, 2'b00};
        bus.dstore = data_q[req_idx][victim_q][cnt_q];
        if (!bus.dwait) begin
          cnt_d = cnt_q + BLKW'(1);
          if (cnt_last) state_d = FILL;
        end
      end

      FILL: begin
        bus.dREN  = 1'b1;
        bus.daddr = {req_tag, req_idx, cnt_q, 2'b00};
        // The line stays invalid until its last word lands.
        valid_d[req_idx][victim_q] = 1'b0;
        if (!bus.dwait) begin
          data_d[req_idx][victim_q][cnt_q] = bus.dload;
          cnt_d = cnt_q + BLKW'(1);
          if (cnt_last) begin
            tag_d[req_idx][victim_q]   = req_tag;
            valid_d[req_idx][victim_q] = 1'b1;
            dirty_d[req_idx][victim_q] = 1'b0;
            state_d                    = IDLE;
          end
        end
      end

      FLUSH_SCAN: begin
        // A written-back entry returns here clean and is then stepped past.
        if (valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q]) begin
          cnt_d   = '0;
          state_d = FLUSH_WB;
        end else if (scan_last) begin
          state_d = STAT;
        end else if (scan_way_q == WAYW'(WAYS - 1)) begin
          scan_way_d = '0;
          scan_set_d = scan_set_q + IDXW'(1);
        end else begin
          scan_way_d = scan_way_q + WAYW'(1);
        end
      end

      FLUSH_WB: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tag_q[scan_set_q][scan_way_q], scan_set_q, cnt_q, 2'b00};
        bus.dstore = data_q[scan_set_q][scan_way_q][cnt_q];
        if (!bus.dwait) begin
          cnt_d = cnt_q + BLKW'(1);
          if (cnt_last) begin
            dirty_d[scan_set_q][scan_way_q] = 1'b0;
            state_d                         = FLUSH_SCAN;
          end
        end
      end

      STAT: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = HITCNT_ADDR;
        bus.dstore = hits_q - misses_q;
        if (!bus.dwait) begin
          state_d = DONE;
          for (int unsigned s = 0; s < SETS; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
              valid_d[s][w] = 1'b0;
              dirty_d[s][w] = 1'b0;
            end
          end
        end
      end

      DONE: state_d = DONE;

      default: state_d = IDLE;
    endcase
  end

  // State and array registers; asynchronous active-low reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      victim_q   <= '0;
      scan_set_q <= '0;
      scan_way_q <= '0;
      hits_q     <= '0;
      misses_q   <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= WAYW'(w);
          for (int unsigned b = 0; b < WORDS; b++) data_q[s][w][b] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      victim_q   <= victim_d;
      scan_set_q <= scan_set_d;
      scan_way_q <= scan_way_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      age_q      <= age_d;
      data_q     <= data_d;
    end
  end
endmodule

// File: tb/tb_dcache_nway.sv
// Scoreboard bench for dcache_nway (8 sets, 2 ways, 2 words).
// Address map: [2] word, [5:3] set, [31:6] tag. Unwritten memory reads as
// {16'hC0DE, addr[15:0]}.
module tb_dcache_nway;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  dcache_nway_if bus();

  dcache_nway #(
    .SETS(8), .WAYS(2), .WORDS(2), .HITCNT_ADDR(32'h3100)
  ) dut (
    .CLK(clk), .nRST(nrst), .bus(bus)
  );

  typedef struct { logic wr; int unsigned lat; logic [31:0] data; } hit_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_t;

  hit_t        exp_hit_q[$];
  mem_t        exp_mem_q[$];
  logic [31:0] mem [logic [31:0]];
  int unsigned cycle = 0;
  int unsigned req_cycle = 0;
  int unsigned stall_n = 0;
  int unsigned wait_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cycle++;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_t m;
    m.we = we; m.addr = a; m.data = d;
    exp_mem_q.push_back(m);
  endtask

  // Issue one request, expecting dhit after 'lat' cycles; held until dhit.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input int unsigned lat, input logic [31:0] rexp);
    hit_t h;
    logic got;
    h.wr = we; h.lat = lat; h.data = rexp;
    exp_hit_q.push_back(h);
    @(posedge clk); #1;
    bus.dmemREN = !we; bus.dmemWEN = we; bus.dmemaddr = a; bus.dmemstore = wd;
    req_cycle = cycle;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #3;
      if (bus.dhit) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL req_timeout: addr %h got no dhit expected dhit within 100 cycles", a);
    end
    @(posedge clk); #1;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
  endtask

  // Memory responder: stall_n wait cycles per transfer, then complete.
  initial begin
    bus.dwait = 1'b0;
    bus.dload = '0;
    forever begin
      @(negedge clk);
      if (bus.dREN || bus.dWEN) begin
        if (wait_cnt < stall_n) begin
          bus.dwait = 1'b1;
          wait_cnt++;
        end else begin
          bus.dwait = 1'b0;
          wait_cnt  = 0;
          if (bus.dWEN) mem[bus.daddr] = bus.dstore;
          else          bus.dload = mem_rd(bus.daddr);
        end
      end else begin
        bus.dwait = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every dhit and every completed transfer.
  initial begin
    logic        pa, pw;
    logic [31:0] pad, pst;
    hit_t        h;
    mem_t        m;
    pa = 1'b0; pw = 1'b0; pad = '0; pst = '0;
    forever begin
      @(negedge clk); #3;
      if (bus.dhit) begin
        if (exp_hit_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dhit: got dhit=1 expected 0 (addr %h)", bus.dmemaddr);
        end else begin
          h = exp_hit_q.pop_front();
          check32("hit_latency", cycle - req_cycle, h.lat);
          if (!h.wr) check32("dmemload", bus.dmemload, h.data);
        end
      end
      if (bus.dREN || bus.dWEN) begin
        check32("ren_wen_exclusive", {31'd0, bus.dREN & bus.dWEN}, 32'd0);
        if (pa && pw) begin
          check32("daddr_stable", bus.daddr, pad);
          check32("dstore_stable", bus.dstore, pst);
        end
        if (!bus.dwait) begin
          if (exp_mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem: got %s %h expected none", bus.dWEN ? "write" : "read", bus.daddr);
          end else begin
            m = exp_mem_q.pop_front();
            check32("mem_we", {31'd0, bus.dWEN}, {31'd0, m.we});
            check32("mem_addr", bus.daddr, m.addr);
            if (m.we) check32("mem_wdata", bus.dstore, m.data);
          end
        end
      end
      pa  = bus.dREN || bus.dWEN;
      pw  = bus.dwait;
      pad = bus.daddr;
      pst = bus.dstore;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got;
    nrst = 1'b0;
    bus.halt = 1'b0; bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
    bus.dmemaddr = '0; bus.dmemstore = '0;
    mem[32'h40] = 32'hA;
    mem[32'h44] = 32'hB;
    repeat (2) @(posedge clk);
    @(negedge clk); #3;
    check32("reset_ctrl", {28'd0, bus.dhit, bus.dREN, bus.dWEN, bus.flushed}, 32'd0);
    check32("reset_daddr", bus.daddr, 32'd0);
    check32("reset_dstore", bus.dstore, 32'd0);
    check32("reset_dmemload", bus.dmemload, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Cold read: fill 0x40/0x44 into set 0 way 0.
    push_mem(1'b0, 32'h40, '0); push_mem(1'b0, 32'h44, '0);
    do_req(1'b0, 32'h40, '0, 3, 32'hA);
    do_req(1'b1, 32'h40, 32'hDEAD, 0, '0);
    do_req(1'b0, 32'h40, '0, 0, 32'hDEAD);

    // Set 0 contention: T1=0x80 into way 1, T0 reused, T2=0xC0 evicts T1.
    push_mem(1'b0, 32'h80, '0); push_mem(1'b0, 32'h84, '0);
    do_req(1'b0, 32'h80, '0, 3, 32'hC0DE0080);
    do_req(1'b0, 32'h40, '0, 0, 32'hDEAD);
    push_mem(1'b0, 32'hC0, '0); push_mem(1'b0, 32'hC4, '0);
    do_req(1'b0, 32'hC0, '0, 3, 32'hC0DE00C0);
    do_req(1'b0, 32'h44, '0, 0, 32'hB);
    push_mem(1'b0, 32'h80, '0); push_mem(1'b0, 32'h84, '0);
    do_req(1'b0, 32'h80, '0, 3, 32'hC0DE0080);

    // Dirty eviction of T0 with 3 wait cycles per transfer: 4 x 4 + 1.
    stall_n = 3;
    push_mem(1'b1, 32'h40, 32'hDEAD); push_mem(1'b1, 32'h44, 32'hB);
    push_mem(1'b0, 32'h100, '0); push_mem(1'b0, 32'h104, '0);
    do_req(1'b1, 32'h100, 32'h1234, 17, '0);
    stall_n = 0;

    // Second dirty block in set 1, then re-read the written-back T0.
    push_mem(1'b0, 32'h48, '0); push_mem(1'b0, 32'h4C, '0);
    do_req(1'b1, 32'h48, 32'h55, 3, '0);
    push_mem(1'b0, 32'h40, '0); push_mem(1'b0, 32'h44, '0);
    do_req(1'b0, 32'h40, '0, 3, 32'hDEAD);

    // Flush: 11 hits, 7 misses -> statistic 4.
    push_mem(1'b1, 32'h100, 32'h1234); push_mem(1'b1, 32'h104, 32'hC0DE0104);
    push_mem(1'b1, 32'h48, 32'h55);    push_mem(1'b1, 32'h4C, 32'hC0DE004C);
    push_mem(1'b1, 32'h3100, 32'd4);
    @(posedge clk); #1;
    bus.halt = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #3;
      if (bus.flushed) got = 1'b1;
    end
    check32("flushed", {31'd0, bus.flushed}, 32'd1);
    check32("flush_mem_done", exp_mem_q.size(), 32'd0);

    // DONE ignores requests.
    @(posedge clk); #1;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      check32("done_no_dhit", {31'd0, bus.dhit}, 32'd0);
      check32("done_no_mem", {30'd0, bus.dREN, bus.dWEN}, 32'd0);
    end
    @(posedge clk); #1;
    bus.dmemREN = 1'b0; bus.halt = 1'b0; nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk); #3;
    check32("flushed_cleared", {31'd0, bus.flushed}, 32'd0);

    // Reset pulsed while a fill of 0x200 is stalled.
    stall_n = 5;
    @(posedge clk); #1;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h200;
    repeat (3) @(posedge clk);
    #1;
    check32("fill_in_progress", {31'd0, bus.dREN}, 32'd1);
    nrst = 1'b0;
    #2;
    check32("midreset_ctrl", {28'd0, bus.dhit, bus.dREN, bus.dWEN, bus.flushed}, 32'd0);
    check32("midreset_daddr", bus.daddr, 32'd0);
    check32("midreset_dmemload", bus.dmemload, 32'd0);
    bus.dmemREN = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    stall_n = 0;
    push_mem(1'b0, 32'h200, '0); push_mem(1'b0, 32'h204, '0);
    do_req(1'b0, 32'h200, '0, 3, 32'hC0DE0200);
    do_req(1'b0, 32'h204, '0, 0, 32'hC0DE0204);

    repeat (3) @(posedge clk);
    check32("hit_queue_empty", exp_hit_q.size(), 32'd0);
    check32("mem_queue_empty", exp_mem_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
